// File: rtl/nn_pkg.sv
// Shared types and default sizes for the layer serializer family.
package nn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int NN_DEFAULT         = 10;
  localparam int DATA_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/layer_serializer_seq_argmax.sv
// Running signed argmax over one serialized frame; ties keep the lowest index.
// Result is published the cycle after the frame's last beat.
module seq_argmax
  import nn_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_WIDTH_DEFAULT,
  parameter int IW        = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat_valid,
  input  logic                        beat_first,
  input  logic                        beat_last,
  input  logic signed [dataWidth-1:0] beat_data,
  input  logic [IW-1:0]               beat_idx,
  output logic [IW-1:0]               class_idx,
  output logic                        class_valid
);

  logic signed [dataWidth-1:0] max_reg;
  logic [IW-1:0]               idx_reg;
  logic                        take;

  // First beat always seeds the maximum; later beats must be strictly larger.
  assign take = beat_first || (beat_data > max_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_reg     <= '0;
      idx_reg     <= '0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (beat_valid) begin
        if (take) begin
          max_reg <= beat_data;
          idx_reg <= beat_idx;
        end
        if (beat_last) begin
          class_idx   <= take ? beat_idx : idx_reg;
          class_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Captures a full layer output when every neuron is valid and shifts it out one element per cycle.
// Optional argmax of each frame is built when LAYER_SERIALIZER_ARGMAX_EN is defined.
module layer_serializer
  import nn_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           par_valid,
  input  logic [NN*dataWidth-1:0] par_data,
  output logic                    ser_valid,
  output logic [dataWidth-1:0]    ser_data,
  output logic                    busy,
  output logic                    overrun_err,
  output logic                    valid_err,
  output logic [$clog2(NN)-1:0]   class_idx,
  output logic                    class_valid
);

  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NN - 1);

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [dataWidth-1:0] buffer_reg [NN];
  logic [dataWidth-1:0] par_elem   [NN];
  logic                 trigger;
  logic                 partial;
  logic                 at_last;

  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_unpack
      assign par_elem[gi] = par_data[gi*dataWidth +: dataWidth];
    end
  endgenerate

  assign trigger = &par_valid;
  assign partial = (|par_valid) && !trigger;
  assign at_last = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      overrun_err <= 1'b0;
      valid_err   <= 1'b0;
      for (int i = 0; i < NN; i++) buffer_reg[i] <= '0;
    end else begin
      if (partial) valid_err <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            for (int i = 0; i < NN; i++) buffer_reg[i] <= par_elem[i];
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            cnt_reg <= '0;
            // A trigger on the final beat chains the next frame with no gap.
            if (trigger) begin
              for (int i = 0; i < NN; i++) buffer_reg[i] <= par_elem[i];
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (trigger) overrun_err <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == SHIFT);
  assign ser_valid = busy;
  assign ser_data  = busy ? buffer_reg[cnt_reg] : '0;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  seq_argmax #(
    .NN        (NN),
    .dataWidth (dataWidth),
    .IW        ($clog2(NN))
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .beat_valid  (busy),
    .beat_first  (cnt_reg == '0),
    .beat_last   (at_last),
    .beat_data   (ser_data),
    .beat_idx    (cnt_reg[$clog2(NN)-1:0]),
    .class_idx   (class_idx),
    .class_valid (class_valid)
  );
`else
  assign class_idx   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NN, default 10: number of neurons in the driving layer, which is also the number of serialized elements per frame.
REQ-002 Parameter dataWidth, default 16: width in bits of one neuron output, signed two's complement.
REQ-003 Port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port par_valid  input  NN  per-neuron output-valid strobes from the layer.
REQ-006 Port par_data  input  NN*dataWidth  layer outputs; element i occupies bits [i*dataWidth +: dataWidth].
REQ-007 Port ser_valid  output  1  qualifies ser_data; drives the next layer's input-valid.
REQ-008 Port ser_data  output  dataWidth  serialized element; drives the next layer's input.
REQ-009 Port busy  output  1  high while a frame is being shifted out.
REQ-010 Port overrun_err  output  1  sticky flag: a frame arrived while the block could not accept it.
REQ-011 Port valid_err  output  1  sticky flag: par_valid was partially asserted.
REQ-012 Port class_idx  output  $clog2(NN)  argmax index of the last completed frame.
REQ-013 Port class_valid  output  1  one-cycle strobe qualifying class_idx.

Function
REQ-014 The capture trigger SHALL be &par_valid, sampled on the rising edge of clk.
REQ-015 The state machine SHALL have two states: IDLE and SHIFT.
REQ-016 IDLE -> SHIFT on a trigger: all NN elements are latched into an internal buffer and the element counter is set to 0.
REQ-017 In SHIFT, ser_valid=1 and ser_data=buffer[cnt]; cnt increments by one each cycle.
REQ-018 In SHIFT, cnt==NN-1 with no trigger SHALL move the block to IDLE.
REQ-019 Latency: for a trigger at edge T, element i SHALL appear at cycle T+1+i, for i=0..NN-1.
REQ-020 ser_valid SHALL be high for exactly NN consecutive cycles per accepted frame.
REQ-021 Back-to-back frames: a trigger in SHIFT with cnt==NN-1 SHALL be accepted, reload the buffer and set cnt=0, with no bubble on ser_valid.
REQ-022 A trigger in SHIFT with cnt<NN-1 SHALL be dropped and SHALL set overrun_err; the frame in flight continues unchanged.
REQ-023 |par_valid && !&par_valid SHALL set valid_err and SHALL NOT start a capture.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 overrun_err and valid_err SHALL clear only on reset.
REQ-026 ser_data SHALL be 0 whenever ser_valid=0.

Reset
REQ-027 When rst is asserted: state=IDLE, cnt=0, buffer=0, and ser_valid, ser_data, busy, overrun_err, valid_err, class_idx and class_valid all 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; the first post-reset output is produced only after a new trigger.

Configuration
REQ-029 Macro LAYER_SERIALIZER_ARGMAX_EN SHALL control the argmax feature.
REQ-030 With the macro defined, the block tracks the running signed maximum during SHIFT.
REQ-031 With the macro defined, an element strictly greater than the running maximum replaces it, so ties resolve to the lowest index.
REQ-032 With the macro defined, class_idx updates and class_valid pulses for one cycle on the cycle after a frame's last ser_valid beat, i.e. T+NN+1.
REQ-033 With the macro defined and back-to-back frames, the class_valid pulse of frame k SHALL coincide with element 0 of frame k+1.
REQ-034 Without the macro, no argmax logic is built, class_idx is tied to 0 and class_valid is tied to 0; all ports remain present.

Structure
REQ-035 Shared package nn_pkg SHALL hold the state enum (IDLE, SHIFT) and the default NN and dataWidth constants.
REQ-036 The argmax tracker SHALL be a sub-module named seq_argmax, instantiated only under LAYER_SERIALIZER_ARGMAX_EN.

Verification
REQ-037 Single frame: NN=10, elements 0x0001..0x000A, par_valid=10'h3FF for one cycle -> ser_data 0x0001..0x000A on cycles T+1..T+10; busy high for the same 10 cycles.
REQ-038 Back-to-back: second trigger at T+10 -> 20 contiguous ser_valid beats; overrun_err stays 0.
REQ-039 Overrun: second trigger at T+4 -> overrun_err=1; the first frame's output is unaltered; the block is IDLE after T+10.
REQ-040 Partial valid: par_valid=10'h00F -> valid_err=1; ser_valid and busy stay 0.
REQ-041 Argmax (macro on): elements {-5, 7, 3, 7, 0x8000, ...} with all remaining elements <7 -> class_idx=1 with class_valid high at T+11 only; with the macro off, class_valid never rises.
REQ-042 Reset at T+5 -> all outputs 0 on the next edge; a new trigger then produces a full, correct frame.
